uart_byte_receiver: RTL and testbench

UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_byte_receiver.sv | 182 ++++++++++++++++++
 tb/tb_uart_byte_receiver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART byte receiver.
// UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } rx_state_t;

    // Clocks per oversample tick; never below 1 so the divider always advances.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; both flops reset to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic Rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// Oversampling 8N1 UART receiver; tvalid rises 1 clock after the stop-bit sample, rx->rx_s is 2 clocks.
// A byte finishing while tvalid=1 and tready=0 is dropped with an overrun pulse. UART_RX_PARITY_EN adds even parity.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              rx,
    output logic              tvalid,
    output logic [DATA_W-1:0] tdata,
    input  logic              tready,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    localparam int DIV    = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_W);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TCNT_W-1:0] MID_TICK  = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] LAST_TICK = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(DATA_W - 1);

    logic rx_s, rx_prev, tick;
    logic stop_ok, stop_bad;
    rx_state_t state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [TCNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d, par_ev;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .Rst (Rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Divider is held at zero in IDLE so the first tick lands DIV clocks after start detection.
    assign tick = (state_q != IDLE) && (div_cnt_q == DIV_LAST);

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_prev    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= (state_q == IDLE || tick) ? '0 : div_cnt_q + DIV_W'(1);
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_prev    <= rx_s;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        par_ev     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d  = 1'b0;
`endif
                if (rx_prev && !rx_s) state_d = START;
            end
            START: if (tick) begin
                if (tick_cnt_q == MID_TICK) begin
                    tick_cnt_d = '0;
                    state_d    = rx_s ? IDLE : DATA;
                end else begin
                    tick_cnt_d = tick_cnt_q + TCNT_W'(1);
                end
            end
            DATA: if (tick) begin
                if (tick_cnt_q == LAST_TICK) begin
                    tick_cnt_d = '0;
                    shift_d    = {rx_s, shift_q[DATA_W-1:1]};
                    bit_cnt_d  = bit_cnt_q + BCNT_W'(1);
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt_q == LAST_BIT) state_d = PARITY;
`else
                    if (bit_cnt_q == LAST_BIT) state_d = STOP;
`endif
                end else begin
                    tick_cnt_d = tick_cnt_q + TCNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                if (tick_cnt_q == LAST_TICK) begin
                    tick_cnt_d = '0;
                    par_bad_d  = ^{shift_q, rx_s};
                    par_ev     = par_bad_d;
                    state_d    = STOP;
                end else begin
                    tick_cnt_d = tick_cnt_q + TCNT_W'(1);
                end
            end
`endif
            STOP: if (tick) begin
                if (tick_cnt_q == LAST_TICK) begin
                    tick_cnt_d = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        stop_ok = !par_bad_q;
`else
                        stop_ok = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = BREAK;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TCNT_W'(1);
                end
            end
            BREAK: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            tvalid    <= 1'b0;
            tdata     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (stop_ok && tvalid && !tready) begin
                overrun <= 1'b1;
            end else if (stop_ok) begin
                tdata  <= shift_q;
                tvalid <= 1'b1;
            end else if (tvalid && tready) begin
                tvalid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) parity_err <= 1'b0;
        else     parity_err <= par_ev;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Randomised frame stimulus with a queue-based scoreboard and an independent output monitor.
module tb_uart_byte_receiver;

    localparam int CLK_HZ = 50000000;
    localparam int BAUD   = 115200;
    localparam int OS     = 16;
    localparam int BIT    = (CLK_HZ / (BAUD * OS)) * OS;

    typedef enum logic [1:0] {EV_BYTE, EV_FRAME, EV_OVR, EV_PAR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  data;
    } ev_t;

    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic       rx = 1'b1;
    logic       tready = 1'b1;
    logic       tvalid, frame_err, overrun, parity_err;
    logic [7:0] tdata;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    bit  stall = 1'b0;
    bit  rand_rdy = 1'b0;
    bit  model_full = 1'b0;

    uart_byte_receiver #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .Rst        (Rst),
        .rx         (rx),
        .tvalid     (tvalid),
        .tdata      (tdata),
        .tready     (tready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (stall)         tready = 1'b0;
        else if (rand_rdy) tready = ($urandom_range(3) != 0);
        else               tready = 1'b1;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic check_event(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got %s 0x%02h, expected nothing", k.name(), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_BYTE && e.data != d)) begin
                miscompares++;
                $display("FAIL event: got %s 0x%02h, expected %s 0x%02h",
                         k.name(), d, e.kind.name(), e.data);
            end
        end
    endtask

    // Monitor: turns DUT output activity into events and checks hold stability.
    logic       tv_prev = 1'b0, rdy_prev = 1'b0;
    logic [7:0] td_prev = 8'h00;
    always @(negedge clk) begin
        logic new_byte;
        if (Rst) begin
            tv_prev  = 1'b0;
            rdy_prev = 1'b0;
        end else begin
            if (tv_prev && !rdy_prev && tvalid) begin
                vectors++;
                if (tdata !== td_prev) begin
                    miscompares++;
                    $display("FAIL hold_stable: got 0x%02h, expected 0x%02h", tdata, td_prev);
                end
            end
            new_byte = tvalid && (!tv_prev || rdy_prev);
            if (new_byte && (frame_err || overrun || parity_err)) begin
                vectors++;
                miscompares++;
                $display("FAIL pulse_with_byte: got errs %b%b%b with new byte, expected 000",
                         frame_err, overrun, parity_err);
            end
            if (new_byte)   check_event(EV_BYTE, tdata);
            if (parity_err) check_event(EV_PAR, 8'h00);
            if (frame_err)  check_event(EV_FRAME, 8'h00);
            if (overrun)    check_event(EV_OVR, 8'h00);
            tv_prev  = tvalid;
            rdy_prev = tready;
            td_prev  = tdata;
        end
    end

    task automatic push_ev(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, {7'd0, tvalid}, 8'h00);
        chk({tag, "_tdata"}, tdata, 8'h00);
        chk({tag, "_errs"}, {5'd0, frame_err, overrun, parity_err}, 8'h00);
    endtask

    // Reference: outcome of a whole frame from the line-level rules.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip,
                              input int abort_bit);
        bit par_bad;
        par_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad = par_flip;
`endif
        if (abort_bit < 0) begin
            if (par_bad)       push_ev(EV_PAR, 8'h00);
            if (!stop_bit)     push_ev(EV_FRAME, 8'h00);
            else if (!par_bad) begin
                if (model_full) push_ev(EV_OVR, 8'h00);
                else begin
                    push_ev(EV_BYTE, d);
                    model_full = stall;
                end
            end
        end
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == abort_bit) begin
                repeat (BIT / 2) @(posedge clk);
                Rst = 1'b1;
                rx  = 1'b1;
                @(negedge clk);
                check_reset_outputs("mid_reset");
                @(posedge clk);
                Rst = 1'b0;
                model_full = 1'b0;
                repeat (2 * BIT) @(posedge clk);
                return;
            end
            repeat (BIT) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (BIT) @(posedge clk);
`endif
        rx = stop_bit;
        repeat (BIT) @(posedge clk);
        rx = 1'b1;
        repeat (BIT) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        Rst = 1'b0;
        repeat (BIT) @(posedge clk);

        send_frame(8'h0A, 1'b1, 1'b0, -1);

        rx = 1'b0;
        repeat (100) @(posedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        @(negedge clk);
        chk("glitch_tvalid", {7'd0, tvalid}, 8'h00);

        send_frame(8'h55, 1'b0, 1'b0, -1);
        send_frame(8'h31, 1'b1, 1'b0, -1);

        stall = 1'b1;
        @(posedge clk);
        send_frame(8'h41, 1'b1, 1'b0, -1);
        send_frame(8'h42, 1'b1, 1'b0, -1);
        @(negedge clk);
        chk("held_tdata", tdata, 8'h41);
        chk("held_tvalid", {7'd0, tvalid}, 8'h01);
        stall = 1'b0;
        model_full = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("accept_tvalid", {7'd0, tvalid}, 8'h00);

        send_frame(8'h7E, 1'b1, 1'b0, 4);
        send_frame(8'h23, 1'b1, 1'b0, -1);
        @(negedge clk);
        chk("after_reset_tdata", tdata, 8'h23);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1, -1);
        send_frame(8'h03, 1'b1, 1'b0, -1);
`endif

        rand_rdy = 1'b1;
        for (int n = 0; n < 5; n++) begin
            send_frame(8'($urandom_range(255)), ($urandom_range(4) != 0),
                       ($urandom_range(3) == 0), -1);
        end
        rand_rdy = 1'b0;
        repeat (BIT) @(posedge clk);

        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got nothing, expected %s 0x%02h", e.kind.name(), e.data);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
